// File: rtl/alu_share_arbiter_pkg.sv
// Shared widths and op-code encodings for the shared-ALU arbiter and its ALU.
// Optional fixed-priority arbitration is enabled by defining ALU_ARB_FIXED_PRIO_EN.
package alu_share_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int OP_W    = 3;
  localparam int NUM_REQ = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_LUI  = 3'b011,
    OP_SLT  = 3'b100,
    OP_SLTU = 3'b101,
    OP_SUB  = 3'b110,
    OP_NONE = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] srca,
  input  logic [DATA_W-1:0] srcb,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);

  logic ltu;
  logic lts;

  always_comb begin
    ltu = (srca < srcb);
    // Differing signs decide the signed compare on their own.
    lts = (srca[DATA_W-1] != srcb[DATA_W-1]) ? srca[DATA_W-1] : ltu;
    result = '0;
    case (op)
      OP_AND:  result = srca & srcb;
      OP_OR:   result = srca | srcb;
      OP_ADD:  result = srca + srcb;
      OP_LUI:  result = srca | {srcb[15:0], 16'h0000};
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, lts};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, ltu};
      OP_SUB:  result = srca - srcb;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one ALU with a registered, back-pressurable result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [DATA_W-1:0]   req0_srca,
  input  logic [DATA_W-1:0]   req0_srcb,
  input  logic [OP_W-1:0]     req0_op,
  input  logic [DATA_W-1:0]   req1_srca,
  input  logic [DATA_W-1:0]   req1_srcb,
  input  logic [OP_W-1:0]     req1_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_result
);

  logic [1:0]        grant;
  logic              free;
  logic              xfer;
  logic [DATA_W-1:0] alu_srca;
  logic [DATA_W-1:0] alu_srcb;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;

  logic              rsp_valid_reg;
  logic              rsp_id_reg;
  logic [DATA_W-1:0] rsp_result_reg;

  assign free = !rsp_valid_reg || rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = 2'b01;
      default: grant = 2'b00;
    endcase
  end
`else
  // Holds the requester granted most recently; the other one wins the next tie.
  logic last_grant_reg;

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_reg <= 1'b1;
    end else if (xfer) begin
      last_grant_reg <= grant[1];
    end
  end
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant[gi] & free;
  end

  assign xfer = |req_ready;

  // Operand mux follows the grant so ready never depends on operand values.
  assign alu_srca = grant[1] ? req1_srca : req0_srca;
  assign alu_srcb = grant[1] ? req1_srcb : req0_srcb;
  assign alu_op   = grant[1] ? req1_op   : req0_op;

  alu_share_arbiter_alu u_alu (
    .srca   (alu_srca),
    .srcb   (alu_srcb),
    .op     (alu_op),
    .result (alu_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
    end else if (xfer) begin
      rsp_valid_reg  <= 1'b1;
      rsp_id_reg     <= grant[1];
      rsp_result_reg <= alu_result;
    end else if (rsp_ready) begin
      rsp_valid_reg  <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed steps plus randomized traffic vs a reference model.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic        m_valid;
  logic        m_id;
  logic [31:0] m_result;
  int          m_last;
  logic [1:0]  acc;

  alu_share_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_srca  (req0_srca),
    .req0_srcb  (req0_srcb),
    .req0_op    (req0_op),
    .req1_srca  (req1_srca),
    .req1_srcb  (req1_srcb),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      3'd3:    return a | (b * 32'h1_0000);
      3'd4:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd5:    return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      3'd6:    return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int winner(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (m_last == 0) ? 1 : 0;
`endif
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_id     = 1'b0;
    m_result = 32'd0;
    m_last   = 1;
    acc      = 2'b00;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    logic [1:0] exp_ready;
    int w;
    @(negedge clk);
    w = winner(req_valid);
    exp_ready = (w >= 0 && (!m_valid || rsp_ready)) ? (2'b01 << w) : 2'b00;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), 32'(m_id));
    chk("rsp_result", rsp_result, m_result);
    @(posedge clk);
    acc = exp_ready;
    if (exp_ready != 2'b00) begin
      m_result = (w == 1) ? alu_ref(req1_srca, req1_srcb, req1_op) : alu_ref(req0_srca, req0_srcb, req0_op);
      m_id     = (w == 1);
      m_valid  = 1'b1;
      m_last   = w;
      if (w == 1)
        $display("xfer id=1 op=%0d a=%08h b=%08h exp=%08h", req1_op, req1_srca, req1_srcb, m_result);
      else
        $display("xfer id=0 op=%0d a=%08h b=%08h exp=%08h", req0_op, req0_srca, req0_srcb, m_result);
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (id == 0) begin
      req0_srca = a; req0_srcb = b; req0_op = op;
    end else begin
      req1_srca = a; req1_srcb = b; req1_op = op;
    end
    req_valid[id] = 1'b1;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bit done;
    done = 0;
    set_req(id, a, b, op);
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      done = acc[id];
    end
    if (!done) chk("issue_timeout", 32'd0, 32'd1);
    req_valid[id] = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req0_srca = '0; req0_srcb = '0; req0_op = '0;
    req1_srca = '0; req1_srcb = '0; req1_op = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_id", 32'(rsp_id), 32'd0);
    chk("reset_result", rsp_result, 32'd0);
    reset_n = 1'b1;

    // Tie for four cycles: alternates, first tie goes to requester 0
    set_req(0, 32'd1, 32'd2, 3'b010);
    set_req(1, 32'd10, 32'd3, 3'b110);
    for (int k = 0; k < 4; k++) begin
      cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("tie_seq", 32'(rsp_id), 32'd0);
`else
      chk("tie_seq", 32'(rsp_id), 32'(k % 2));
`endif
    end
    req_valid = 2'b00;

    // Single-requester op coverage
    issue(0, 32'd5, 32'd7, 3'b010);
    chk("add", rsp_result, 32'd12);
    chk("add_id", 32'(rsp_id), 32'd0);
    issue(0, 32'd3, 32'd5, 3'b110);
    chk("sub_wrap", rsp_result, 32'hFFFF_FFFE);
    issue(1, 32'hFFFF_FFFF, 32'd1, 3'b100);
    chk("slt", rsp_result, 32'd1);
    chk("slt_id", 32'(rsp_id), 32'd1);
    issue(1, 32'hFFFF_FFFF, 32'd1, 3'b101);
    chk("sltu", rsp_result, 32'd0);
    issue(1, 32'h0000_1234, 32'h0000_ABCD, 3'b011);
    chk("lui", rsp_result, 32'hABCD_1234);
    issue(1, 32'hDEAD_BEEF, 32'h1234_5678, 3'b111);
    chk("op111", rsp_result, 32'd0);

    // Backpressure: held result, no accepts, then drain and refill together
    issue(0, 32'd100, 32'd23, 3'b010);
    chk("bp_load", rsp_result, 32'd123);
    rsp_ready = 1'b0;
    set_req(0, 32'd9, 32'd4, 3'b110);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_hold", rsp_result, 32'd123);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("refill_acc", 32'(acc), 32'd1);
    chk("refill_result", rsp_result, 32'd5);
    req_valid = 2'b00;

    // Stalled tie: pointer must not rotate while stalled (last grant was requester 0)
    rsp_ready = 1'b0;
    set_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
    set_req(1, 32'h0000_00F0, 32'h0000_0F00, 3'b001);
    repeat (2) cycle();
    rsp_ready = 1'b1;
    cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("stalled_tie_id", 32'(rsp_id), 32'd0);
    chk("stalled_tie_res", rsp_result, 32'hF000_F000);
`else
    chk("stalled_tie_id", 32'(rsp_id), 32'd1);
    chk("stalled_tie_res", rsp_result, 32'h0000_0FF0);
`endif
    req_valid = 2'b00;
    cycle();

    // Randomized traffic; requesters hold payload until accepted
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 1) == 1)
            set_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
          else
            set_req(i, $urandom_range(0, 8), $urandom_range(0, 8), 3'($urandom_range(0, 7)));
          req_valid[i] = ($urandom_range(0, 3) != 0);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset while a result is pending
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    issue(1, 32'h0000_5555, 32'h0000_AAAA, 3'b011);
    chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_id", 32'(rsp_id), 32'd0);
    chk("async_rst_result", rsp_result, 32'd0);
    model_reset();
    #2;
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 32'd2, 32'd2, 3'b010);
    set_req(1, 32'd3, 32'd3, 3'b010);
    cycle();
    chk("post_reset_tie", 32'(rsp_id), 32'd0);
    chk("post_reset_res", rsp_result, 32'd4);
    req_valid = 2'b00;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
